// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter plus IF/ID pipeline register with stall/flush/jump control.
// Optional macro FETCH_PERF_CNT_EN adds a fetch_cnt output that counts IF/ID loads.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
`endif
    output logic [31:0] imem_addr,
    output logic [31:0] pc_if,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic [31:0] pcadd4_id,
    output logic        valid_id
);

    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] pc_id_r;
    logic [31:0] pcadd4_r;
    logic        valid_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic        bubble_s;
    logic        load_s;

    // Next-PC selection and IF/ID load/bubble decision; jump outranks stall.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        bubble_s   = flush | jump;
        load_s     = 1'b0;
        if (jump) begin
            pc_next_s = {jump_target[31:2], 2'b00};
        end else if (stall) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
        if (!bubble_s && !stall) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // PC and IF/ID state; reset wins over everything, en=0 freezes all state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_r     <= RESET_PC;
            inst_r   <= NOP_INST;
            pc_id_r  <= 32'h0000_0000;
            pcadd4_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else if (en) begin
            pc_r <= pc_next_s;
            if (bubble_s) begin
                inst_r   <= NOP_INST;
                pc_id_r  <= 32'h0000_0000;
                pcadd4_r <= 32'h0000_0000;
                valid_r  <= 1'b0;
            end else if (load_s) begin
                inst_r   <= imem_rdata;
                pc_id_r  <= pc_r;
                pcadd4_r <= pc_plus4_s;
                valid_r  <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_r;

    // Count cycles in which IF/ID takes a real instruction; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= 32'h0000_0000;
        end else if (en && load_s) begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    assign fetch_cnt = cnt_r;
`endif

    assign pc_if     = pc_r;
    assign imem_addr = pc_r;
    assign inst_id   = inst_r;
    assign pc_id     = pc_id_r;
    assign pcadd4_id = pcadd4_r;
    assign valid_id  = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn, en, stall, flush, jump;
    logic [31:0] jump_target, imem_addr, imem_rdata, pc_if, inst_id, pc_id, pcadd4_id;
    logic        valid_id;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pcid, m_pa4, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h00A0_0513;
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rstn(rstn), .en(en), .stall(stall), .flush(flush), .jump(jump),
        .jump_target(jump_target), .imem_rdata(imem_rdata),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fetch_cnt),
`endif
        .imem_addr(imem_addr), .pc_if(pc_if), .inst_id(inst_id), .pc_id(pc_id),
        .pcadd4_id(pcadd4_id), .valid_id(valid_id)
    );

    function automatic logic [160:0] obs();
        return {pc_if, imem_addr, inst_id, pc_id, pcadd4_id, valid_id};
    endfunction

    function automatic logic [160:0] exp(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic [31:0] pcid, input logic [31:0] pa4,
                                         input logic v);
        return {pc, pc, inst, pcid, pa4, v};
    endfunction

    task automatic drive(input logic r, input logic e, input logic s, input logic f,
                         input logic j, input logic [31:0] jt);
        rstn = r; en = e; stall = s; flush = f; jump = j; jump_target = jt;
    endtask

    // Advance the model by the stage's priority rules, then clock the DUT.
    task automatic tick();
        if (!rstn) begin
            m_pc = RESET_PC; m_inst = NOP_INST; m_pcid = 32'h0; m_pa4 = 32'h0; m_valid = 1'b0;
            m_cnt = 32'h0;
        end else if (en) begin
            logic [31:0] cur;
            cur = m_pc;
            if (jump) m_pc = jump_target & 32'hFFFF_FFFC;
            else if (!stall) m_pc = cur + 32'd4;
            if (flush || jump) begin
                m_inst = NOP_INST; m_pcid = 32'h0; m_pa4 = 32'h0; m_valid = 1'b0;
            end else if (!stall) begin
                m_inst = mem_word(cur); m_pcid = cur; m_pa4 = cur + 32'd4; m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        tick();
        checks++;
        if (obs() !== exp(RESET_PC, NOP_INST, 32'h0, 32'h0, 1'b0)) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs(), exp(RESET_PC, NOP_INST, 32'h0, 32'h0, 1'b0));
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", fetch_cnt); end
`endif
    endtask

    task automatic test_free_run();
        do_reset();
        tick();
        checks++;
        if (obs() !== exp(32'h0040_0004, 32'h00A0_0513, 32'h0040_0000, 32'h0040_0004, 1'b1)) begin
            errors++; $display("FAIL first_fetch got=%h exp=%h", obs(),
                exp(32'h0040_0004, 32'h00A0_0513, 32'h0040_0000, 32'h0040_0004, 1'b1));
        end
        tick(); tick();
        checks++;
        if (pc_if !== 32'h0040_000C || pc_id !== 32'h0040_0008 || valid_id !== 1'b1) begin
            errors++; $display("FAIL free_run3 got pc_if=%h pc_id=%h exp 0040000c 00400008", pc_if, pc_id);
        end
    endtask

    task automatic test_stall();
        logic [160:0] e;
        do_reset();
        tick(); tick();
        e = exp(32'h0040_0008, mem_word(32'h0040_0004), 32'h0040_0004, 32'h0040_0008, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs(), e); end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = exp(32'h0040_000C, mem_word(32'h0040_0008), 32'h0040_0008, 32'h0040_000C, 1'b1);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL stall_resume got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_jump_stall();
        logic [160:0] e;
        do_reset();
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0103);
        tick();
        e = exp(32'h0040_0100, NOP_INST, 32'h0, 32'h0, 1'b0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL jump_stall got=%h exp=%h", obs(), e); end
        // back-to-back jumps
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0202);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0301);
        tick();
        e = exp(32'h0040_0300, NOP_INST, 32'h0, 32'h0, 1'b0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL jump_b2b got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_flush();
        logic [160:0] e;
        do_reset();
        repeat (4) tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        e = exp(32'h0040_0014, NOP_INST, 32'h0, 32'h0, 1'b0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL flush_only got=%h exp=%h", obs(), e); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL flush_stall got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_wrap();
        logic [160:0] e;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = exp(32'h0000_0000, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_enable_freeze();
        logic [160:0] e;
        do_reset();
        tick();
        e = exp(32'h0040_0004, 32'h00A0_0513, 32'h0040_0000, 32'h0040_0004, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0800);
        tick(); tick();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL en_freeze got=%h exp=%h", obs(), e); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL en_freeze_cnt got=%h exp=1", fetch_cnt); end
`endif
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        repeat (3) tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (obs() !== exp(RESET_PC, NOP_INST, 32'h0, 32'h0, 1'b0)) begin
            errors++; $display("FAIL reset_mid_stall got=%h", obs());
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc_id !== RESET_PC + 32'd4 * (i - 1)) begin
                errors++; $display("FAIL reset_release%0d got pc_id=%h exp=%h", i, pc_id, RESET_PC + 32'd4 * (i - 1));
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (fetch_cnt !== i) begin errors++; $display("FAIL cnt_after_reset%0d got=%0d exp=%0d", i, fetch_cnt, i); end
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom);
            tick();
            checks++;
            if (obs() !== exp(m_pc, m_inst, m_pcid, m_pa4, m_valid)) begin
                errors++; $display("FAIL random%0d got=%h exp=%h", i, obs(), exp(m_pc, m_inst, m_pcid, m_pa4, m_valid));
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL random_cnt%0d got=%h exp=%h", i, fetch_cnt, m_cnt); end
`endif
        end
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_free_run();
        test_stall();
        test_jump_stall();
        test_flush();
        test_wrap();
        test_enable_freeze();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
